// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch/jump flush and interrupt entry sequencing for the 5-stage pipeline
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Jump,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             IDEX_Branch,
  input  logic             EX_BranchTaken,
  input  logic             IRQ,
  input  logic             KernelMode,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXMux,
  output logic             IRQTake,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  typedef enum logic [1:0] {RUN, IRQ_DRAIN, IRQ_TAKE} state_t;
  state_t state, state_nx;
  logic irq_pend, lu, stall, flush;
  assign lu = IDEX_MemRead && IDEX_Rt != 5'd0 &&
              (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXMux   = 1'b1;
    IRQTake   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    state_nx  = RUN;
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXMux   = 1'b0;
    end else if (state == IRQ_TAKE) begin
      IRQTake   = 1'b1;
      IFIDFlush = 1'b1;
      IDEXMux   = 1'b0;
      flush     = 1'b1;
    end else begin
      if (EX_BranchTaken) begin
        IFIDFlush = 1'b1;
        IDEXMux   = 1'b0;
        flush     = 1'b1;
      end else if (lu) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXMux   = 1'b0;
        stall     = 1'b1;
      end else if (IFID_Jump) begin
        IFIDFlush = 1'b1;
        flush     = 1'b1;
      end else if (state == RUN && irq_pend && !KernelMode) begin
        state_nx  = IDEX_Branch ? IRQ_DRAIN : IRQ_TAKE;
      end
      // a drain cycle only lets the branch in EX resolve; entry follows regardless
      if (state == IRQ_DRAIN) state_nx = IRQ_TAKE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      irq_pend   <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state    <= state_nx;
      irq_pend <= (IRQ && !KernelMode) || (irq_pend && state != IRQ_TAKE);
      if (stall && !(&StallCount)) StallCount <= StallCount + CNT_W'(1);
      if (flush && !(&FlushCount)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against an event-level reference model
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic IFID_UsesRt, IFID_Jump, IDEX_MemRead, IDEX_Branch, EX_BranchTaken, IRQ, KernelMode;
  logic pc_w, ifid_w, ifid_fl, idex_mux, irq_take;
  logic pc_w4, ifid_w4, ifid_fl4, idex_mux4, irq_take4;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0] stall_cnt4, flush_cnt4;
  int n_chk = 0, n_err = 0, n_take = 0;
  int m_st = 0;
  bit m_pend = 0;
  longint m_sc = 0, m_fc = 0;
  logic [4:0] tbl [6] = '{5'b11010, 5'b11100, 5'b00000, 5'b11110, 5'b11101, 5'b00100};

  hazard_ctrl dut (.clk(clk), .reset(reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rt(IDEX_Rt), .IDEX_Branch(IDEX_Branch), .EX_BranchTaken(EX_BranchTaken),
    .IRQ(IRQ), .KernelMode(KernelMode), .PCWrite(pc_w), .IFIDWrite(ifid_w),
    .IFIDFlush(ifid_fl), .IDEXMux(idex_mux), .IRQTake(irq_take),
    .StallCount(stall_cnt), .FlushCount(flush_cnt));
  hazard_ctrl #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rt(IDEX_Rt), .IDEX_Branch(IDEX_Branch), .EX_BranchTaken(EX_BranchTaken),
    .IRQ(IRQ), .KernelMode(KernelMode), .PCWrite(pc_w4), .IFIDWrite(ifid_w4),
    .IFIDFlush(ifid_fl4), .IDEXMux(idex_mux4), .IRQTake(irq_take4),
    .StallCount(stall_cnt4), .FlushCount(flush_cnt4));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    {IFID_Rs, IFID_Rt, IDEX_Rt} = '0;
    {IFID_UsesRt, IFID_Jump, IDEX_MemRead, IDEX_Branch, EX_BranchTaken, IRQ, KernelMode} = '0;
  endtask

  // event codes: 0 none, 1 branch, 2 load-use, 3 jump, 4 irq take, 5 reset
  task automatic tick();
    int ev, nst;
    bit lu;
    #1;
    if (reset) begin
      m_st = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    end
    lu = IDEX_MemRead && IDEX_Rt != 0 &&
         (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
    ev = reset ? 5 : m_st == 2 ? 4 : EX_BranchTaken ? 1 : lu ? 2 : IFID_Jump ? 3 : 0;
    check("outs", {pc_w, ifid_w, ifid_fl, idex_mux, irq_take}, tbl[ev]);
    check("outs4", {pc_w4, ifid_w4, ifid_fl4, idex_mux4, irq_take4}, tbl[ev]);
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
    check("stall_cnt4", stall_cnt4, m_sc > 15 ? 15 : m_sc);
    check("flush_cnt4", flush_cnt4, m_fc > 15 ? 15 : m_fc);
    if (irq_take === 1'b1) n_take++;
    nst = m_st == 1 ? 2 : (m_st == 0 && ev == 0 && m_pend && !KernelMode) ? (IDEX_Branch ? 1 : 2) : 0;
    @(posedge clk);
    if (!reset) begin
      m_pend = (IRQ && !KernelMode) || (m_pend && m_st != 2);
      m_sc += (ev == 2);
      m_fc += (ev == 1 || ev == 3 || ev == 4);
      m_st = nst;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    @(negedge clk);
    repeat (3) tick();
    check("rst_pc", pc_w, 0);
    check("rst_flush", ifid_fl, 1);
    reset = 1'b0;
    tick();
    check("rel_pc", pc_w, 1);
    check("rel_mux", idex_mux, 1);
    // loads to $0 or an unread rt never stall
    IDEX_MemRead = 1; IDEX_Rt = 0; IFID_Rs = 0; tick();
    IDEX_Rt = 8; IFID_Rt = 8; IFID_Rs = 1; IFID_UsesRt = 0; tick();
    check("nostall_cnt", stall_cnt, 0);
    idle(); IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8; tick();
    IDEX_MemRead = 0; tick();
    check("lu_cnt", stall_cnt, 1);
    check("lu_after_pc", pc_w, 1);
    IDEX_MemRead = 1; EX_BranchTaken = 1; tick();
    idle(); tick();
    check("br_lu_fc", flush_cnt, 1);
    check("br_lu_sc", stall_cnt, 1);
    IRQ = 1; tick();
    IRQ = 0; IDEX_Branch = 1; tick();
    IDEX_Branch = 0; tick();
    check("drain_take", n_take, 0);
    repeat (3) tick();
    check("take_once", n_take, 1);
    KernelMode = 1; IRQ = 1; tick();
    IRQ = 0; repeat (5) tick();
    KernelMode = 0; repeat (3) tick();
    check("km_mask", n_take, 1);
    for (int i = 0; i < 20; i++) begin
      idle(); IDEX_MemRead = 1; IDEX_Rt = 5; IFID_Rt = 5; IFID_UsesRt = 1; tick();
      idle(); tick();
    end
    check("sat4", stall_cnt4, 15);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      IFID_Rs = 5'($urandom_range(0, 3));
      IFID_Rt = 5'($urandom_range(0, 3));
      IDEX_Rt = 5'($urandom_range(0, 3));
      IFID_UsesRt = 1'($urandom);
      IDEX_MemRead = ($urandom_range(0, 2) == 0);
      IFID_Jump = ($urandom_range(0, 5) == 0);
      EX_BranchTaken = ($urandom_range(0, 5) == 0);
      IDEX_Branch = 1'($urandom);
      IRQ = ($urandom_range(0, 15) == 0);
      KernelMode = ($urandom_range(0, 3) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
